muldiv_sequencer: RTL

//  Iterative multicycle M-extension unit (MUL, MULHU, DIVU, REMU) next to the single-cycle ALU in EX.

---
 rtl/muldiv_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative M-extension unit (MUL, MULHU, DIVU, REMU) that sits next to the
//   single-cycle ALU in EX. One op is accepted per start pulse. A multiply runs
//   a radix-2 shift/add loop and a divide runs a restoring loop, both for XLEN
//   iterations, and then done pulses for one cycle. busy stays high from
//   acceptance until the DONE cycle so the hazard logic can stall IF/EX.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset; has priority over every input
//   start_i   request, sampled only in IDLE
//   op_i      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_i     multiplicand / dividend
//   rs2_i     multiplier / divisor
//   flush_i   abort the in-flight op (branch redirect)
//   busy_o    high in RUN and DONE
//   done_o    one-cycle pulse; result_o is valid in this cycle
//   result_o  result, held until the next op completes
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        op_q, op_d;
  logic [2*XLEN-1:0] p_q, p_d;       // {high accumulator, multiplier shifting out}
  logic [XLEN-1:0]   m_q, m_d;       // multiplicand
  logic [XLEN:0]     r_q, r_d;       // partial remainder
  logic [XLEN-1:0]   q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   d_q, d_d;       // divisor
  logic [XLEN-1:0]   result_q, result_d;

  // One iteration of each datapath, computed from the current registers.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_t, r_next;
  logic [XLEN-1:0]   q_next;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, m_q};
    mul_next = p_q[0] ? {mul_sum, p_q[XLEN-1:1]} : {1'b0, p_q[2*XLEN-1:1]};

    div_shift = {r_q[XLEN-1:0], q_q[XLEN-1]};
    div_t     = div_shift - {1'b0, d_q};
    // Borrow (MSB set) means the divisor did not fit: keep the shifted remainder.
    if (!div_t[XLEN]) begin
      r_next = div_t;
      q_next = {q_q[XLEN-2:0], 1'b1};
    end else begin
      r_next = div_shift;
      q_next = {q_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    p_d      = p_q;
    m_d      = m_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        // flush beats a simultaneous start: nothing is accepted
        if (start_i && !flush_i) begin
          op_d    = op_i;
          count_d = '0;
          p_d     = {{XLEN{1'b0}}, rs2_i};
          m_d     = rs1_i;
          r_d     = '0;
          q_d     = rs1_i;
          d_d     = rs2_i;
          if (op_i[1] && (rs2_i == '0)) begin
            // RISC-V divide-by-zero: DIVU -> all ones, REMU -> dividend
            state_d  = S_DONE;
            result_d = op_i[0] ? rs1_i : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            r_d = r_next;
            q_d = q_next;
          end else begin
            p_d = mul_next;
          end
          // The final iteration and the result capture share one edge, so the
          // result is taken from the post-iteration values.
          if (count_q == LAST) begin
            state_d = S_DONE;
            unique case (op_q)
              2'b00:   result_d = mul_next[XLEN-1:0];
              2'b01:   result_d = mul_next[2*XLEN-1:XLEN];
              2'b10:   result_d = q_next;
              default: result_d = r_next[XLEN-1:0];
            endcase
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      p_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      p_q      <= p_d;
      m_q      <= m_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule
